// File: rtl/roll_conditioner.sv
// roll_conditioner: raw push-button in, debounced die roll level and done strobe out.
// Defining ROLL_LOCKOUT_EN adds a post-roll window in which the button is ignored.
module roll_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int MIN_ROLL_CYCLES = 8,
   parameter int LOCKOUT_CYCLES  = 32
) (
   input  logic clock,
   input  logic reset,
   input  logic button,
   output logic roll,
   output logic done,
   output logic busy
);

   localparam int MAXA = (DEBOUNCE_CYCLES > MIN_ROLL_CYCLES) ?
                         DEBOUNCE_CYCLES : MIN_ROLL_CYCLES;
   localparam int MAXP = (LOCKOUT_CYCLES > MAXA) ? LOCKOUT_CYCLES : MAXA;
   localparam int CW   = $clog2(MAXP) + 1;

   localparam logic [CW-1:0] ONE   = CW'(1);
   localparam logic [CW-1:0] DB_N  = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] MIN_N = CW'(MIN_ROLL_CYCLES);
`ifdef ROLL_LOCKOUT_EN
   localparam logic [CW-1:0] LO_LAST = CW'(LOCKOUT_CYCLES - 1);
`endif

   typedef enum logic [2:0] {
      IDLE,
      PRESS_DB,
      ROLLING,
      RELEASE_DB,
      LOCKOUT
   } state_t;

   state_t        state;
   logic          s1;
   logic          s2;
   logic [CW-1:0] cnt;
   logic          min_done;

   always_ff @(posedge clock) begin
      if (reset) begin
         s1       <= 1'b0;
         s2       <= 1'b0;
         state    <= IDLE;
         cnt      <= '0;
         min_done <= 1'b0;
         roll     <= 1'b0;
         done     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         s1   <= button;
         s2   <= s1;
         done <= 1'b0;
         case (state)
            IDLE: begin
               min_done <= 1'b0;
               if (s2) begin
                  state <= PRESS_DB;
                  cnt   <= ONE;
                  busy  <= 1'b1;
               end
            end
            PRESS_DB: begin
               if (!s2) begin
                  state <= IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else if (cnt == DB_N) begin
                  state <= ROLLING;
                  cnt   <= '0;
                  roll  <= 1'b1;
               end else begin
                  cnt <= cnt + ONE;
               end
            end
            ROLLING: begin
               // Releases before min_done are ignored until it is set.
               if (!s2 && min_done) begin
                  state <= RELEASE_DB;
                  cnt   <= ONE;
               end else begin
                  if (cnt < MIN_N)
                     cnt <= cnt + ONE;
                  if (cnt >= MIN_N - ONE)
                     min_done <= 1'b1;
               end
            end
            RELEASE_DB: begin
               if (s2) begin
                  state <= ROLLING;
                  cnt   <= '0;
               end else if (cnt == DB_N) begin
                  cnt  <= '0;
                  roll <= 1'b0;
                  done <= 1'b1;
`ifdef ROLL_LOCKOUT_EN
                  state <= LOCKOUT;
`else
                  state <= IDLE;
                  busy  <= 1'b0;
`endif
               end else begin
                  cnt <= cnt + ONE;
               end
            end
`ifdef ROLL_LOCKOUT_EN
            LOCKOUT: begin
               if (cnt == LO_LAST) begin
                  state <= IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt + ONE;
               end
            end
`endif
            default: begin
               state <= IDLE;
               cnt   <= '0;
               roll  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
